// File: rtl/accumulator_drain.sv
// Readout sequencer for the accumulator back buffer: walks every bank/entry in
// bank-major order, applies optional per-lane ReLU and streams words over valid/ready.
module accumulator_drain #(
  parameter int BUFFER_WIDTH           = 8,
  parameter int BANK_COUNT             = 256,
  parameter int TILE_SIZE              = 256,
  parameter int SMALLEST_ELEMENT_WIDTH = 4,
  localparam int SEW     = SMALLEST_ELEMENT_WIDTH,
  localparam int W       = 4 * SMALLEST_ELEMENT_WIDTH,
  localparam int BANK_W  = $clog2(TILE_SIZE),
  localparam int ENTRY_W = $clog2(BUFFER_WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         bitwidth,
  input  logic               relu_enable,
  output logic [BANK_W-1:0]  back_buffer_bank_read,
  output logic [ENTRY_W-1:0] back_buffer_bank_entry,
  input  logic [W-1:0]       back_buffer_data_read,
  output logic [W-1:0]       out_data,
  output logic [BANK_W-1:0]  out_bank,
  output logic [ENTRY_W-1:0] out_entry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [BANK_W-1:0]  LAST_BANK  = BANK_W'(BANK_COUNT - 1);
  localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(BUFFER_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  // Clears every lane that is negative when read as two's complement.
  function automatic logic [W-1:0] relu_lanes(input logic [W-1:0] d, input logic [1:0] mode);
    logic [W-1:0] r;
    r = d;
    case (mode)
      2'd0: for (int l = 0; l < 4; l++)
              if ($signed(d[l*SEW +: SEW]) < 0) r[l*SEW +: SEW] = '0;
      2'd1: for (int l = 0; l < 2; l++)
              if ($signed(d[l*2*SEW +: 2*SEW]) < 0) r[l*2*SEW +: 2*SEW] = '0;
      default: if ($signed(d) < 0) r = '0;
    endcase
    return r;
  endfunction

  state_t             state_q;
  logic [1:0]         mode_q;
  logic               relu_q;
  logic [BANK_W-1:0]  bank_q;
  logic [ENTRY_W-1:0] entry_q;
  logic [W-1:0]       out_data_q;
  logic [BANK_W-1:0]  out_bank_q;
  logic [ENTRY_W-1:0] out_entry_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               done_q;

  logic               load_d;
  logic               last_d;
  logic [W-1:0]       data_d;

  assign load_d = !out_valid_q || out_ready;
  assign last_d = (bank_q == LAST_BANK) && (entry_q == LAST_ENTRY);
  assign data_d = relu_q ? relu_lanes(back_buffer_data_read, mode_q) : back_buffer_data_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      relu_q      <= 1'b0;
      bank_q      <= '0;
      entry_q     <= '0;
      out_data_q  <= '0;
      out_bank_q  <= '0;
      out_entry_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        bank_q      <= '0;
        entry_q     <= '0;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            mode_q  <= bitwidth;
            relu_q  <= relu_enable;
            bank_q  <= '0;
            entry_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
          S_RUN: if (load_d) begin
            out_data_q  <= data_d;
            out_bank_q  <= bank_q;
            out_entry_q <= entry_q;
            out_valid_q <= 1'b1;
            // The address parks on the final location while the last word drains.
            if (last_d) begin
              state_q <= S_FLUSH;
            end else if (entry_q == LAST_ENTRY) begin
              entry_q <= '0;
              bank_q  <= bank_q + 1'b1;
            end else begin
              entry_q <= entry_q + 1'b1;
            end
          end
          S_FLUSH: if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign back_buffer_bank_read  = bank_q;
  assign back_buffer_bank_entry = entry_q;
  assign out_data               = out_data_q;
  assign out_bank               = out_bank_q;
  assign out_entry              = out_entry_q;
  assign out_valid              = out_valid_q;
  assign busy                   = busy_q;
  assign done                   = done_q;

endmodule
